// File: rtl/detector_jogada.sv
// Push-button play detector: synchronizes and debounces four buttons, then
// emits a one-cycle pulse per accepted single press (or a flag for multi-press).
module detector_jogada #(
    parameter int DEBOUNCE_CICLOS = 250000
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] botoes,
    output logic       jogada_feita,
    output logic [3:0] jogada,
    output logic       multiplo,
    output logic [1:0] db_estado
);

    localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    typedef enum logic [1:0] {
        ESPERA   = 2'b00,
        PULSO    = 2'b01,
        INVALIDO = 2'b11,
        SEGURA   = 2'b10
    } estado_t;

    function automatic logic eh_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    logic [3:0]    s1_q, s2_q, s2_ant_q;
    logic [3:0]    estavel_q, estavel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    estado_t       state_q, state_d;
    logic [3:0]    jogada_q, jogada_d;
    logic          feita_q, mult_q;

    // Debounce: a new level must stay put for DEBOUNCE_CICLOS samples
    always_comb begin
        cnt_d     = cnt_q;
        estavel_d = estavel_q;
        if (s2_q != s2_ant_q) begin
            cnt_d = '0;
        end else if (s2_q == estavel_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            estavel_d = s2_q;
            cnt_d     = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Play FSM; SEGURA swallows everything until a full release
    always_comb begin
        state_d  = state_q;
        jogada_d = jogada_q;
        case (state_q)
            ESPERA: begin
                if (eh_onehot(estavel_q)) begin
                    state_d  = PULSO;
                    jogada_d = estavel_q;
                end else if (estavel_q != 4'b0000) begin
                    state_d = INVALIDO;
                end else begin
                    state_d = ESPERA;
                end
            end
            PULSO:    state_d = SEGURA;
            INVALIDO: state_d = SEGURA;
            SEGURA: begin
                if (estavel_q == 4'b0000) begin
                    state_d = ESPERA;
                end else begin
                    state_d = SEGURA;
                end
            end
            default:  state_d = ESPERA;
        endcase
    end

    // All state, with clear taking priority
    always_ff @(posedge clock) begin
        if (clear) begin
            s1_q      <= 4'b0000;
            s2_q      <= 4'b0000;
            s2_ant_q  <= 4'b0000;
            estavel_q <= 4'b0000;
            cnt_q     <= '0;
            state_q   <= ESPERA;
            jogada_q  <= 4'b0000;
            feita_q   <= 1'b0;
            mult_q    <= 1'b0;
        end else begin
            s1_q      <= botoes;
            s2_q      <= s1_q;
            s2_ant_q  <= s2_q;
            estavel_q <= estavel_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            jogada_q  <= jogada_d;
            feita_q   <= (state_d == PULSO);
            mult_q    <= (state_d == INVALIDO);
        end
    end

    assign jogada_feita = feita_q;
    assign multiplo     = mult_q;
    assign jogada       = jogada_q;
    assign db_estado    = state_q;

endmodule
